// File: rtl/pdp8_bin_loader_pkg.sv
// Shared definitions for the PDP-8 BIN paper-tape loader.
// - Byte-class tags: the top two bits of a tape byte select leader, field, origin or data.
// - Loader FSM state encoding.
// - 12-bit modulo add used for the running tape checksum.
package pdp8_loader_pkg;

  // Top two bits of a tape byte carry its class.
  localparam logic [7:0] LDR_MASK   = 8'o300;
  localparam logic [7:0] LDR_TAG    = 8'o200;
  localparam logic [7:0] FIELD_TAG  = 8'o300;
  localparam logic [7:0] ORIGIN_TAG = 8'o100;
  localparam logic [7:0] DATA_TAG   = 8'o000;

  typedef enum logic [1:0] {
    ClsData   = 2'b00,
    ClsOrigin = 2'b01,
    ClsLeader = 2'b10,
    ClsField  = 2'b11
  } byte_cls_t;

  typedef enum logic [2:0] {
    StIdle,
    StLeader,
    StSkipLdr,
    StHi,
    StLo,
    StWrite,
    StDone,
    StErr
  } state_t;

  function automatic byte_cls_t classify(input logic [7:0] b);
    logic [7:0] tag;
    tag = b & LDR_MASK;
    if (tag == LDR_TAG) begin
      return ClsLeader;
    end else if (tag == FIELD_TAG) begin
      return ClsField;
    end else if (tag == ORIGIN_TAG) begin
      return ClsOrigin;
    end
    return ClsData;
  endfunction

  function automatic logic [11:0] add12(input logic [11:0] a, input logic [11:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pdp8_bin_loader_if.sv
// Byte-stream and memory-write bus of the BIN loader.
// - rx_data/rx_valid/rx_ready: tape byte stream, consumed on rx_valid && rx_ready.
// - ram_write_req/ram_ma/ram_out/ram_done: external-RAM write handshake, request held until done.
// The loader uses the master modport; the byte source and RAM model use slave.
interface pdp8_bin_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ram_write_req;
  logic [14:0] ram_ma;
  logic [11:0] ram_out;
  logic        ram_done;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  ram_done,
    output rx_ready,
    output ram_write_req,
    output ram_ma,
    output ram_out
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output ram_done,
    input  rx_ready,
    input  ram_write_req,
    input  ram_ma,
    input  ram_out
  );
endinterface

// File: rtl/pdp8_bin_loader.sv
// PDP-8 BIN-format tape loader. Parses leader, field, origin and data frames from the byte
// stream, writes data words to memory and holds the CPU in reset until the trailer arrives.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   start_i          one-cycle arm pulse, honoured only in idle/done/error
//   bus_io           byte stream in, memory write request out (master modport)
//   cpu_hold_o       CPU reset hold while loading (and after a failed load if configured)
//   busy_o, done_o   load in progress / trailer seen
//   checksum_ok_o    checksum result, valid with done_o
//   error_o          framing error on the second byte of a frame
//   word_count_o     data words committed to memory
module pdp8_bin_loader
  import pdp8_loader_pkg::*;
#(
  parameter logic [2:0] DEFAULT_FIELD = 3'o0,
  parameter bit         HOLD_ON_ERROR = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  pdp8_bin_loader_if.master          bus_io,
  output logic                       cpu_hold_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       checksum_ok_o,
  output logic                       error_o,
  output logic [14:0]                word_count_o
);

  state_t      state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  // Sum of every summed byte except those of the pending word.
  logic [11:0] sum_q, sum_d;

  // The newest data word is held back: if a trailer follows, it was the checksum.
  logic        pend_valid_q, pend_valid_d;
  logic [14:0] pend_ma_q, pend_ma_d;
  logic [11:0] pend_w_q, pend_w_d;
  logic [11:0] pend_sum_q, pend_sum_d;

  // Frame that forced a commit; applied once the write completes.
  logic        apply_origin_q, apply_origin_d;
  logic [11:0] apply_w_q, apply_w_d;
  logic [11:0] apply_sum_q, apply_sum_d;

  logic        rx_ready_q, rx_ready_d;
  logic        req_q, req_d;
  logic [14:0] ram_ma_q, ram_ma_d;
  logic [11:0] ram_out_q, ram_out_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cks_ok_q, cks_ok_d;
  logic        error_q, error_d;
  logic [14:0] wc_q, wc_d;

  logic        fire;
  logic        hi_fire;
  logic [7:0]  rx_byte;
  byte_cls_t   cls;
  logic [11:0] frame_w;
  logic [11:0] frame_sum;
  logic [11:0] sum_after_pend;

  always_comb begin
    rx_byte        = bus_io.rx_data;
    fire           = bus_io.rx_valid && rx_ready_q;
    cls            = classify(rx_byte);
    frame_w        = {hi_byte_q[5:0], rx_byte[5:0]};
    frame_sum      = add12({4'd0, hi_byte_q}, {4'd0, rx_byte});
    sum_after_pend = add12(sum_q, pend_sum_q);
    // SKIPLDR treats every non-leader byte exactly like HI.
    hi_fire        = fire && ((state_q == StHi) ||
                              ((state_q == StSkipLdr) && (cls != ClsLeader)));

    state_d        = state_q;
    field_d        = field_q;
    addr_d         = addr_q;
    hi_byte_d      = hi_byte_q;
    sum_d          = sum_q;
    pend_valid_d   = pend_valid_q;
    pend_ma_d      = pend_ma_q;
    pend_w_d       = pend_w_q;
    pend_sum_d     = pend_sum_q;
    apply_origin_d = apply_origin_q;
    apply_w_d      = apply_w_q;
    apply_sum_d    = apply_sum_q;
    ram_ma_d       = ram_ma_q;
    ram_out_d      = ram_out_q;
    hold_d         = hold_q;
    done_d         = done_q;
    cks_ok_d       = cks_ok_q;
    error_d        = error_q;
    wc_d           = wc_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d      = StLeader;
          done_d       = 1'b0;
          error_d      = 1'b0;
          cks_ok_d     = 1'b0;
          wc_d         = '0;
          sum_d        = '0;
          pend_valid_d = 1'b0;
          pend_sum_d   = '0;
          field_d      = DEFAULT_FIELD;
          hold_d       = 1'b1;
        end
      end
      StLeader: begin
        if (fire && (cls == ClsLeader)) begin
          state_d = StSkipLdr;
        end
      end
      StSkipLdr, StHi: begin
        // Handled by hi_fire below.
      end
      StLo: begin
        if (fire) begin
          if (rx_byte[7:6] != 2'b00) begin
            state_d = StErr;
            error_d = 1'b1;
            hold_d  = HOLD_ON_ERROR;
          end else if (pend_valid_q) begin
            apply_origin_d = hi_byte_q[6];
            apply_w_d      = frame_w;
            apply_sum_d    = frame_sum;
            ram_ma_d       = pend_ma_q;
            ram_out_d      = pend_w_q;
            state_d        = StWrite;
          end else if (hi_byte_q[6]) begin
            addr_d  = frame_w;
            sum_d   = add12(sum_q, frame_sum);
            state_d = StHi;
          end else begin
            pend_valid_d = 1'b1;
            pend_ma_d    = {field_q, addr_q};
            pend_w_d     = frame_w;
            pend_sum_d   = frame_sum;
            addr_d       = addr_q + 12'd1;
            state_d      = StHi;
          end
        end
      end
      StWrite: begin
        if (bus_io.ram_done) begin
          wc_d         = wc_q + 15'd1;
          sum_d        = sum_after_pend;
          pend_valid_d = 1'b0;
          pend_sum_d   = '0;
          if (apply_origin_q) begin
            addr_d = apply_w_q;
            sum_d  = add12(sum_after_pend, apply_sum_q);
          end else begin
            pend_valid_d = 1'b1;
            pend_ma_d    = {field_q, addr_q};
            pend_w_d     = apply_w_q;
            pend_sum_d   = apply_sum_q;
            addr_d       = addr_q + 12'd1;
          end
          state_d = StHi;
        end
      end
    endcase

    if (hi_fire) begin
      unique case (cls)
        ClsLeader: begin
          cks_ok_d = pend_valid_q && (pend_w_q == sum_q);
          done_d   = 1'b1;
          hold_d   = HOLD_ON_ERROR && !cks_ok_d;
          state_d  = StDone;
        end
        ClsField: begin
          field_d = rx_byte[5:3];
        end
        ClsOrigin, ClsData: begin
          hi_byte_d = rx_byte;
          state_d   = StLo;
        end
      endcase
    end

    rx_ready_d = state_d inside {StLeader, StSkipLdr, StHi, StLo};
    req_d      = (state_d == StWrite);
    busy_d     = !(state_d inside {StIdle, StDone, StErr});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      field_q        <= DEFAULT_FIELD;
      addr_q         <= '0;
      hi_byte_q      <= '0;
      sum_q          <= '0;
      pend_valid_q   <= 1'b0;
      pend_ma_q      <= '0;
      pend_w_q       <= '0;
      pend_sum_q     <= '0;
      apply_origin_q <= 1'b0;
      apply_w_q      <= '0;
      apply_sum_q    <= '0;
      rx_ready_q     <= 1'b0;
      req_q          <= 1'b0;
      ram_ma_q       <= '0;
      ram_out_q      <= '0;
      hold_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cks_ok_q       <= 1'b0;
      error_q        <= 1'b0;
      wc_q           <= '0;
    end else begin
      state_q        <= state_d;
      field_q        <= field_d;
      addr_q         <= addr_d;
      hi_byte_q      <= hi_byte_d;
      sum_q          <= sum_d;
      pend_valid_q   <= pend_valid_d;
      pend_ma_q      <= pend_ma_d;
      pend_w_q       <= pend_w_d;
      pend_sum_q     <= pend_sum_d;
      apply_origin_q <= apply_origin_d;
      apply_w_q      <= apply_w_d;
      apply_sum_q    <= apply_sum_d;
      rx_ready_q     <= rx_ready_d;
      req_q          <= req_d;
      ram_ma_q       <= ram_ma_d;
      ram_out_q      <= ram_out_d;
      hold_q         <= hold_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cks_ok_q       <= cks_ok_d;
      error_q        <= error_d;
      wc_q           <= wc_d;
    end
  end

  assign bus_io.rx_ready      = rx_ready_q;
  assign bus_io.ram_write_req = req_q;
  assign bus_io.ram_ma        = ram_ma_q;
  assign bus_io.ram_out       = ram_out_q;
  assign cpu_hold_o           = hold_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign checksum_ok_o        = cks_ok_q;
  assign error_o              = error_q;
  assign word_count_o         = wc_q;

endmodule

// File: tb/tb_pdp8_bin_loader.sv
// Directed bench for pdp8_bin_loader: good tape, bad checksum, field byte, address wrap,
// framing error with re-arm, and a slow RAM write interrupted by reset.
module tb_pdp8_bin_loader;
  import pdp8_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        checksum_ok;
  logic        error;
  logic [14:0] word_count;

  pdp8_bin_loader_if bus ();

  pdp8_bin_loader #(
    .DEFAULT_FIELD(3'o0),
    .HOLD_ON_ERROR(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .bus_io       (bus),
    .cpu_hold_o   (cpu_hold),
    .busy_o       (busy),
    .done_o       (done),
    .checksum_ok_o(checksum_ok),
    .error_o      (error),
    .word_count_o (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          resp_delay = 0;
  logic [14:0] wr_ma[$];
  logic [11:0] wr_out[$];
  logic [7:0]  tape[$];

  // RAM model: answers each request after resp_delay cycles, logs the write.
  initial begin
    bit alive;
    bus.ram_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ram_write_req) begin
        alive = 1'b1;
        for (int i = 0; i < resp_delay && alive; i++) begin
          @(negedge clk);
          if (!bus.ram_write_req) alive = 1'b0;
        end
        if (alive) begin
          wr_ma.push_back(bus.ram_ma);
          wr_out.push_back(bus.ram_out);
          bus.ram_done = 1'b1;
          @(negedge clk);
          bus.ram_done = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $error("FAIL rx_ready timeout: observed 0 expected 1 (byte %0o)", b);
    end else begin
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send_tape();
    for (int i = 0; i < tape.size(); i++) send_byte(tape[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !error && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done && !error) begin
      checks++;
      errors++;
      $error("FAIL end timeout: done/error observed 0 expected 1");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_ready"}, 32'(bus.rx_ready), 0);
    check({tag, " req"}, 32'(bus.ram_write_req), 0);
    check({tag, " ram_ma"}, 32'(bus.ram_ma), 0);
    check({tag, " ram_out"}, 32'(bus.ram_out), 0);
    check({tag, " cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " checksum_ok"}, 32'(checksum_ok), 0);
    check({tag, " error"}, 32'(error), 0);
    check({tag, " word_count"}, 32'(word_count), 0);
  endtask

  task automatic check_writes(input string tag, input logic [14:0] ma0, input logic [11:0] d0,
                              input logic [14:0] ma1, input logic [11:0] d1);
    check({tag, " writes"}, 32'(wr_ma.size()), 2);
    if (wr_ma.size() == 2) begin
      check({tag, " ma0"}, 32'(wr_ma[0]), 32'(ma0));
      check({tag, " data0"}, 32'(wr_out[0]), 32'(d0));
      check({tag, " ma1"}, 32'(wr_ma[1]), 32'(ma1));
      check({tag, " data1"}, 32'(wr_out[1]), 32'(d1));
    end
  endtask

  task automatic load_good_tape(input logic [7:0] cks_lo);
    tape = '{8'o200, 8'o200, 8'o200, 8'o200, 8'o200, 8'o200, 8'o200, 8'o200,
             8'o102, 8'o000, 8'o012, 8'o034, 8'o056, 8'o077, 8'o003, 8'o025, 8'o200};
    tape[15] = cks_lo;
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Good tape: o1234 @ 0:0200, o5677 @ 0:0201, checksum o0325.
    pulse_start();
    check("start hold", 32'(cpu_hold), 1);
    check("start busy", 32'(busy), 1);
    wr_ma.delete(); wr_out.delete();
    load_good_tape(8'o025);
    send_tape();
    wait_end();
    check_writes("good", 15'o00200, 12'o1234, 15'o00201, 12'o5677);
    check("good word_count", 32'(word_count), 2);
    check("good done", 32'(done), 1);
    check("good checksum_ok", 32'(checksum_ok), 1);
    check("good cpu_hold", 32'(cpu_hold), 0);
    check("good busy", 32'(busy), 0);

    // Checksum off by one: same memory, hold stays.
    pulse_start();
    check("rearm done cleared", 32'(done), 0);
    wr_ma.delete(); wr_out.delete();
    load_good_tape(8'o026);
    send_tape();
    wait_end();
    check_writes("badcks", 15'o00200, 12'o1234, 15'o00201, 12'o5677);
    check("badcks done", 32'(done), 1);
    check("badcks checksum_ok", 32'(checksum_ok), 0);
    check("badcks cpu_hold", 32'(cpu_hold), 1);

    // Field byte 0320 ahead of the origin: field 2, not summed.
    pulse_start();
    wr_ma.delete(); wr_out.delete();
    load_good_tape(8'o025);
    tape.insert(8, 8'o320);
    send_tape();
    wait_end();
    check_writes("field", 15'o20200, 12'o1234, 15'o20201, 12'o5677);
    check("field checksum_ok", 32'(checksum_ok), 1);

    // Origin 7777: second word wraps to 0:0000. Checksum o0521.
    pulse_start();
    wr_ma.delete(); wr_out.delete();
    tape = '{8'o200, 8'o200, 8'o177, 8'o077, 8'o012, 8'o034, 8'o056, 8'o077,
             8'o005, 8'o021, 8'o200};
    send_tape();
    wait_end();
    check_writes("wrap", 15'o07777, 12'o1234, 15'o00000, 12'o5677);
    check("wrap checksum_ok", 32'(checksum_ok), 1);
    check("wrap word_count", 32'(word_count), 2);

    // Framing error: 0100 as the second byte of a data frame.
    pulse_start();
    wr_ma.delete(); wr_out.delete();
    tape = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o100};
    send_tape();
    wait_end();
    check("err error", 32'(error), 1);
    check("err done", 32'(done), 0);
    check("err busy", 32'(busy), 0);
    check("err cpu_hold", 32'(cpu_hold), 1);
    check("err rx_ready", 32'(bus.rx_ready), 0);
    check("err state", 32'(dut.state_q), 32'(StErr));
    check("err writes", 32'(wr_ma.size()), 0);

    // Re-arm after error and load a good tape.
    pulse_start();
    check("rearm error cleared", 32'(error), 0);
    wr_ma.delete(); wr_out.delete();
    load_good_tape(8'o025);
    send_tape();
    wait_end();
    check_writes("rearm", 15'o00200, 12'o1234, 15'o00201, 12'o5677);
    check("rearm checksum_ok", 32'(checksum_ok), 1);
    check("rearm cpu_hold", 32'(cpu_hold), 0);

    // Slow RAM: request and bus stay put, no bytes accepted, then reset mid-wait.
    resp_delay = 20;
    pulse_start();
    wr_ma.delete(); wr_out.delete();
    tape = '{8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o056, 8'o077};
    send_tape();
    for (int i = 0; i < 15; i++) begin
      check("slow req", 32'(bus.ram_write_req), 1);
      check("slow ram_ma", 32'(bus.ram_ma), 32'(15'o00200));
      check("slow ram_out", 32'(bus.ram_out), 32'(12'o1234));
      check("slow rx_ready", 32'(bus.rx_ready), 0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midwrite reset");
    check("midwrite state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midwrite writes", 32'(wr_ma.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
